// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor computing a - b mod 2^WIDTH, one bit per
//   clock, LSB first. A subtraction is accepted in IDLE on start. It runs for
//   exactly WIDTH cycles and then holds the result in DONE until ack.
//
// Ports
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a subtraction (sampled in IDLE only)
//   a      in   minuend    [WIDTH-1:0], latched on the accepting edge
//   b      in   subtrahend [WIDTH-1:0], latched on the accepting edge
//   ack    in   result acknowledge (sampled in DONE only)
//   busy   out  high while the bits are being processed (RUN)
//   done   out  high while the result is held (DONE)
//   diff   out  a - b mod 2^WIDTH of the last completed operation
//   borrow out  a < b (unsigned) of the last completed operation
//   zero   out  diff == 0 of the last completed operation
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  // The counter must be able to hold WIDTH-1. The result shift register
  // shifts in from the top, so WIDTH is expected to be at least 2.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg;

  // One full-subtractor slice on the current LSBs of the operand shifters.
  logic             ai;
  logic             bi;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  assign ai       = a_sh_reg[0];
  assign bi       = b_sh_reg[0];
  assign d_bit    = ai ^ bi ^ br_reg;
  assign br_next  = (~ai & bi) | (~(ai ^ bi) & br_reg);
  // Each new bit enters at the top. After WIDTH shifts, bit i sits at position i.
  assign res_next = {d_bit, res_sh_reg[WIDTH-1:1]};
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      cnt_reg    <= '0;
      br_reg     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow     <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            cnt_reg   <= '0;
            br_reg    <= 1'b0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end

        RUN: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          res_sh_reg <= res_next;
          br_reg     <= br_next;
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_bit) begin
            // The outputs change only here, so partial results never appear.
            diff      <= res_next;
            borrow    <= br_next;
            zero      <= (res_next == '0);
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end

        DONE: begin
          // start is ignored here, even when it arrives together with ack.
          if (ack) begin
            done      <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 6;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ack;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;

  int errors;
  int checks;

  // Expected contents of the result registers, from the last completed op.
  int prev_diff;
  int prev_borrow;
  int prev_zero;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .ack    (ack),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int diff;
    int borrow;
    int zero;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain modular arithmetic on whole operands.
  function automatic int ref_diff(input int av, input int bv);
    return (av - bv + (1 << W)) % (1 << W);
  endfunction

  // Called at the negedge right after the accepting edge. It counts busy
  // cycles, checks that the outputs keep their old values while running,
  // and then checks the completed result.
  task automatic run_to_done(input int ea, input int eb, input bit scramble);
    int cyc;
    int ed;
    int eb_r;
    int ez;
    ed   = ref_diff(ea, eb);
    eb_r = (ea < eb) ? 1 : 0;
    ez   = (ed == 0) ? 1 : 0;
    cyc  = 0;
    while (busy && cyc < W + 4) begin
      chk("run_done_low", int'(done), 0);
      chk("run_diff_held", int'(diff), prev_diff);
      chk("run_borrow_held", int'(borrow), prev_borrow);
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      cyc++;
      @(negedge clk);
    end
    chk("latency", cyc, W);
    chk("done", int'(done), 1);
    chk("busy_in_done", int'(busy), 0);
    chk("diff", int'(diff), ed);
    chk("borrow", int'(borrow), eb_r);
    chk("zero", int'(zero), ez);
    $display("op a=%0d b=%0d -> diff=%0d borrow=%0d zero=%0d latency=%0d",
             ea, eb, diff, borrow, zero, cyc);
    prev_diff   = ed;
    prev_borrow = eb_r;
    prev_zero   = ez;
  endtask

  // Holds done for a while, then acknowledges it. The caller is at a negedge.
  task automatic finish_op(input int hold);
    ack = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("done_hold", int'(done), 1);
      chk("diff_hold", int'(diff), prev_diff);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("done_after_ack", int'(done), 0);
    chk("busy_after_ack", int'(busy), 0);
    chk("diff_idle", int'(diff), prev_diff);
    chk("zero_idle", int'(zero), prev_zero);
  endtask

  // Complete operation. The caller is at a negedge in IDLE.
  task automatic do_op(input int av, input int bv, input int hold);
    a     = W'(av);
    b     = W'(bv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_done(av, bv, 1'b1);
    finish_op(hold);
  endtask

  vec_t tbl[7];

  initial begin
    errors      = 0;
    checks      = 0;
    prev_diff   = 0;
    prev_borrow = 0;
    prev_zero   = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    ack         = 1'b0;
    a           = '0;
    b           = '0;

    tbl[0] = '{a: 45, b: 12, diff: 33, borrow: 0, zero: 0};
    tbl[1] = '{a: 12, b: 45, diff: 31, borrow: 1, zero: 0};
    tbl[2] = '{a: 20, b: 20, diff: 0,  borrow: 0, zero: 1};
    tbl[3] = '{a: 63, b: 0,  diff: 63, borrow: 0, zero: 0};
    tbl[4] = '{a: 0,  b: 63, diff: 1,  borrow: 1, zero: 0};
    tbl[5] = '{a: 1,  b: 2,  diff: 63, borrow: 1, zero: 0};
    tbl[6] = '{a: 32, b: 31, diff: 1,  borrow: 0, zero: 0};

    // Outputs while reset is asserted
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_borrow", int'(borrow), 0);
    chk("rst_zero", int'(zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors: constant expectations, and the model is checked as well
    for (int i = 0; i < 7; i++) begin
      chk("tbl_model", ref_diff(tbl[i].a, tbl[i].b), tbl[i].diff);
      a     = W'(tbl[i].a);
      b     = W'(tbl[i].b);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      run_to_done(tbl[i].a, tbl[i].b, 1'b1);
      chk("tbl_diff", int'(diff), tbl[i].diff);
      chk("tbl_borrow", int'(borrow), tbl[i].borrow);
      chk("tbl_zero", int'(zero), tbl[i].zero);
      finish_op(i % 3);
      // ack in IDLE must not do anything
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("idle_ack_done", int'(done), 0);
      chk("idle_ack_busy", int'(busy), 0);
    end

    // Random operations compared with the model
    for (int i = 0; i < 20; i++) begin
      do_op(int'($urandom_range(0, (1 << W) - 1)),
            int'($urandom_range(0, (1 << W) - 1)),
            int'($urandom_range(0, 3)));
    end

    // Hold start high and change the operands during RUN.
    // Then assert start together with ack.
    a     = W'(40);
    b     = W'(9);
    start = 1'b1;
    @(negedge clk);
    run_to_done(40, 9, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("start_in_done_ignored", int'(done), 1);
      chk("start_in_done_busy", int'(busy), 0);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_start_idle_done", int'(done), 0);
    chk("ack_start_idle_busy", int'(busy), 0);
    a = W'(10);
    b = W'(3);
    @(negedge clk);
    start = 1'b0;
    chk("start_after_ack_accepted", int'(busy), 1);
    run_to_done(10, 3, 1'b1);
    finish_op(1);

    // Reset during RUN, then start on the first edge after reset is released.
    a     = W'(50);
    b     = W'(7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_diff", int'(diff), 0);
    chk("abort_borrow", int'(borrow), 0);
    prev_diff   = 0;
    prev_borrow = 0;
    prev_zero   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(5, 9, 1);

    // Reset during DONE: the result is cleared and nothing is delivered.
    a     = W'(30);
    b     = W'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_done(30, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_done_state", int'(done), 0);
    chk("abort_done_diff", int'(diff), 0);
    prev_diff   = 0;
    prev_borrow = 0;
    prev_zero   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", int'(busy), 0);
    do_op(17, 17, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 6, giving operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH, minuend; sampled on the accepting edge only.
REQ-006 SHALL have port b, input, WIDTH, subtrahend; sampled on the accepting edge only.
REQ-007 SHALL have port ack, input, 1, consumer acknowledge of the result; sampled only in DONE.
REQ-008 SHALL have port busy, output, 1, high in RUN.
REQ-009 SHALL have port done, output, 1, high in DONE; result valid.
REQ-010 SHALL have port diff, output, WIDTH, result a - b mod 2^WIDTH.
REQ-011 SHALL have port borrow, output, 1, high when a < b unsigned.
REQ-012 SHALL have port zero, output, 1, high when diff == 0.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE with start=1 at a rising edge: latch a and b into internal shift registers, clear the bit counter and the internal borrow flop, and enter RUN.
REQ-015 SHALL, in IDLE with start=0: remain in IDLE.
REQ-016 SHALL process one bit per cycle in RUN, LSB first: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-017 SHALL shift each d into an internal result shift register, LSB first, so that bit i lands at position i after WIDTH shifts.
REQ-018 SHALL count bits 0..WIDTH-1 in RUN and enter DONE on the edge that processes bit WIDTH-1.
REQ-019 SHALL, on that same edge, load diff, borrow (the final br_next) and zero into the output registers.
REQ-020 SHALL give a latency of exactly WIDTH cycles: start accepted at edge k, done high after edge k+WIDTH.
REQ-021 SHALL hold diff, borrow and zero stable outside that completion edge; partial results are never visible on the outputs.
REQ-022 SHALL remain in DONE with done=1 until ack=1 is sampled, then enter IDLE.
REQ-023 SHALL ignore start in RUN and DONE; operands are not re-latched.
REQ-024 SHALL, on start=1 and ack=1 on the same edge in DONE, return to IDLE and drop start; start must be re-asserted.
REQ-025 SHALL ignore ack outside DONE.
REQ-026 SHALL keep busy and done mutually exclusive; both are low in IDLE.
REQ-027 SHALL keep diff, borrow and zero at their last completed values through IDLE and the next RUN.
REQ-028 SHALL ignore any operand change on a or b after the accepting edge for the remainder of the operation.

Reset
REQ-029 SHALL, on rst_n=0, immediately and asynchronously force: state=IDLE, busy=0, done=0, diff=0, borrow=0, zero=0, counter=0, and all internal shift and borrow registers=0.
REQ-030 SHALL abort an operation in progress when rst_n asserts mid-RUN or mid-DONE; no result is delivered.
REQ-031 SHALL accept start on the first rising edge after rst_n deasserts.

Verification
REQ-032 SHALL pass: a=45, b=12, start pulse -> busy for 6 cycles; done after edge k+6; diff=33, borrow=0, zero=0.
REQ-033 SHALL pass: a=12, b=45 -> diff=31, borrow=1, zero=0.
REQ-034 SHALL pass: a=20, b=20 -> diff=0, borrow=0, zero=1; a=63, b=0 -> diff=63, borrow=0; a=0, b=63 -> diff=1, borrow=1.
REQ-035 SHALL pass: start held high and a/b changed during RUN -> result matches the first latched operands; no restart until after ack.
REQ-036 SHALL pass: rst_n low at cycle 3 of RUN -> busy=0, done=0, diff=0 immediately; a new operation then completes correctly.
REQ-037 SHALL pass: in DONE, ack=1 and start=1 on the same edge -> IDLE, no new operation; a start on the next edge is accepted.
